// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported data memory.
// Port 0 is the CPU load/store unit and port 1 is the program/DMA loader.
// Each access is range- and alignment-checked. A registered response
// follows one cycle after the grant.
module dmem_arbiter #(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] BASE  = 32'h00001000,
    parameter logic [WIDTH-1:0] LIMIT = 32'h0001FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_addr0,
    input  logic [WIDTH-1:0] req_addr1,
    input  logic [1:0]       req_we,
    input  logic [1:0]       req_mode,
    input  logic [WIDTH-1:0] req_wdata0,
    input  logic [WIDTH-1:0] req_wdata1,
    output logic [1:0]       rsp_valid,
    output logic [1:0]       rsp_err,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    output logic             mem_mode,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             rsp_port_q, rsp_port_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic             grant;
    logic             win;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             sel_we;
    logic             sel_mode;
    logic             legal;

    // Pick the winner; with both ports valid the rr pointer decides, and nothing is granted in reset.
    always_comb begin
        grant = 1'b0;
        win   = 1'b0;
        if (rst_n) begin
            case (req_valid)
                2'b01: begin
                    grant = 1'b1;
                    win   = 1'b0;
                end
                2'b10: begin
                    grant = 1'b1;
                    win   = 1'b1;
                end
                2'b11: begin
                    grant = 1'b1;
                    win   = rr_q;
                end
                default: begin
                    grant = 1'b0;
                    win   = 1'b0;
                end
            endcase
        end
    end

    // Route the winner (port 0 when idle) to memory and check range and alignment.
    always_comb begin
        sel_addr  = win ? req_addr1  : req_addr0;
        sel_wdata = win ? req_wdata1 : req_wdata0;
        sel_we    = req_we[win];
        sel_mode  = req_mode[win];
        legal     = (sel_addr >= BASE) && (sel_addr <= LIMIT) &&
                    (sel_mode || (sel_addr[1:0] == 2'b00));
        req_ready = {grant & win, grant & ~win};
        mem_addr  = rst_n ? sel_addr  : '0;
        mem_wdata = rst_n ? sel_wdata : '0;
        mem_mode  = rst_n & sel_mode;
        mem_we    = grant & sel_we & legal;
    end

    // Next state, priority pointer and response capture; loads latch memory data only when legal.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        rsp_port_d  = rsp_port_q;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            IDLE:    state_d = grant ? RESP : IDLE;
            RESP:    state_d = grant ? RESP : IDLE;
            default: state_d = IDLE;
        endcase
        if (grant) begin
            rr_d        = ~win;
            rsp_port_d  = win;
            rsp_err_d   = ~legal;
            rsp_rdata_d = (legal && !sel_we) ? mem_rdata : '0;
        end
    end

    // State and response registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            rsp_port_q  <= rsp_port_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Response pulse goes to the port that won the previous cycle.
    always_comb begin
        rsp_valid = (state_q == RESP) ? {rsp_port_q, ~rsp_port_q} : 2'b00;
        rsp_err   = rsp_valid & {2{rsp_err_q}};
        rsp_rdata = rsp_rdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by randomized traffic,
// checked against a request-level reference model of arbitration and memory contents.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_addr0, req_addr1;
    logic [1:0]  req_we;
    logic [1:0]  req_mode;
    logic [31:0] req_wdata0, req_wdata1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_mode;
    logic [31:0] mem_rdata;

    bit [31:0]   ram    [0:32767];
    bit [31:0]   refMem [0:32767];

    int          vectors;
    int          miscompares;
    int          prio;
    bit          expRv;
    int          expPort;
    bit          expErr;
    logic [31:0] expRdata;
    bit          lastGrant;
    int          lastWin;
    logic [1:0]  obsReady;
    logic [1:0]  obsRv;

    dmem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_we     (req_we),
        .req_mode   (req_mode),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_mode   (mem_mode),
        .mem_rdata  (mem_rdata)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stand-in: synchronous write, little-endian byte lanes.
    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_mode)
                ram[mem_addr[16:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
            else
                ram[mem_addr[16:2]] <= mem_wdata;
        end
    end

    // Memory stand-in: combinational read, zero-extended byte in byte mode.
    always_comb begin
        mem_rdata = ram[mem_addr[16:2]];
        if (mem_mode)
            mem_rdata = {24'h0, ram[mem_addr[16:2]][8*mem_addr[1:0] +: 8]};
    end

    function automatic bit legalModel(input logic [31:0] a, input bit m);
        return (a >= 32'h0000_1000) && (a <= 32'h0001_FFFF) && (m || (a % 4 == 0));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic setReq(input int p, input bit v, input logic [31:0] a,
                          input bit w, input bit m, input logic [31:0] d);
        if (p == 0) begin
            req_valid[0] = v;
            req_addr0    = a;
            req_we[0]    = w;
            req_mode[0]  = m;
            req_wdata0   = d;
        end else begin
            req_valid[1] = v;
            req_addr1    = a;
            req_we[1]    = w;
            req_mode[1]  = m;
            req_wdata1   = d;
        end
    endtask

    task automatic newReq(input int p);
        int          kind;
        logic [31:0] a;
        bit          m;
        kind = $urandom_range(0, 9);
        m    = bit'($urandom_range(0, 1));
        a    = 32'h1000 + 32'($urandom_range(0, 63));
        case (kind)
            0: a = 32'h0000_0FFC;
            1: a = 32'h0002_0000;
            2: a = 32'h0001_FFFC;
            3: a = 32'h0000_0FFF;
            default: if (!m && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        endcase
        setReq(p, $urandom_range(0, 3) != 0, a, bit'($urandom_range(0, 1)), m, $urandom);
    endtask

    // One clock cycle: check outputs at the falling edge against the model, then advance the model.
    task automatic applyStimulus(input string tag);
        int          win;
        bit          g;
        bit          lg;
        bit          w;
        bit          m;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] word;
        int          off;
        @(negedge clk);
        obsReady = req_ready;
        obsRv    = rsp_valid;
        checkOutput({tag, ":rsp_valid"}, 32'(rsp_valid),
                    expRv ? (expPort == 1 ? 32'h2 : 32'h1) : 32'h0);
        if (expRv) begin
            checkOutput({tag, ":rsp_err"}, 32'(rsp_err),
                        expErr ? (expPort == 1 ? 32'h2 : 32'h1) : 32'h0);
            checkOutput({tag, ":rsp_rdata"}, rsp_rdata, expRdata);
        end
        g   = (req_valid != 2'b00);
        win = (req_valid == 2'b11) ? prio : (req_valid[1] ? 1 : 0);
        a   = (win == 1) ? req_addr1 : req_addr0;
        d   = (win == 1) ? req_wdata1 : req_wdata0;
        w   = req_we[win];
        m   = req_mode[win];
        lg  = legalModel(a, m);
        checkOutput({tag, ":req_ready"}, 32'(req_ready), g ? (32'h1 << win) : 32'h0);
        checkOutput({tag, ":mem_we"}, 32'(mem_we), 32'(g && w && lg));
        if (g) begin
            checkOutput({tag, ":mem_addr"}, mem_addr, a);
            checkOutput({tag, ":mem_mode"}, 32'(mem_mode), 32'(m));
            if (w && lg) checkOutput({tag, ":mem_wdata"}, mem_wdata, d);
        end
        expRv = g;
        if (g) begin
            off      = int'(a[1:0]);
            word     = refMem[a[16:2]];
            expPort  = win;
            expErr   = !lg;
            if (!lg || w)
                expRdata = 32'h0;
            else
                expRdata = m ? {24'h0, word[8*off +: 8]} : word;
            if (lg && w) begin
                if (m) refMem[a[16:2]][8*off +: 8] = d[7:0];
                else   refMem[a[16:2]] = d;
            end
            prio = 1 - win;
        end
        lastGrant = g;
        lastWin   = win;
        @(posedge clk);
        #1;
    endtask

    // Assert reset between clock edges, check every output is forced low, then release.
    task automatic resetAndCheck(input string tag);
        rst_n = 1'b0;
        #1;
        checkOutput({tag, ":req_ready"}, 32'(req_ready), 32'h0);
        checkOutput({tag, ":mem_we"}, 32'(mem_we), 32'h0);
        checkOutput({tag, ":mem_addr"}, mem_addr, 32'h0);
        checkOutput({tag, ":mem_wdata"}, mem_wdata, 32'h0);
        checkOutput({tag, ":mem_mode"}, 32'(mem_mode), 32'h0);
        checkOutput({tag, ":rsp_valid"}, 32'(rsp_valid), 32'h0);
        checkOutput({tag, ":rsp_err"}, 32'(rsp_err), 32'h0);
        checkOutput({tag, ":rsp_rdata"}, rsp_rdata, 32'h0);
        @(negedge clk);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        prio      = 0;
        expRv     = 1'b0;
        lastGrant = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        int cnt;
        vectors     = 0;
        miscompares = 0;
        prio        = 0;
        expRv       = 1'b0;
        rst_n       = 1'b1;
        setReq(0, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h1234_5678);
        setReq(1, 1'b1, 32'h1004, 1'b1, 1'b0, 32'h8765_4321);
        #2;
        resetAndCheck("reset");

        $display("[TB] single load");
        setReq(0, 1'b1, 32'h1000, 1'b1, 1'b0, 32'hDEAD_BEEF);
        applyStimulus("sw_1000");
        setReq(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        setReq(1, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0);
        applyStimulus("lw_1000");
        checkOutput("single_load_valid", 32'(rsp_valid), 32'h2);
        checkOutput("single_load_data", rsp_rdata, 32'hDEAD_BEEF);
        setReq(1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus("idle");

        $display("[TB] contention from reset");
        setReq(0, 1'b1, 32'h1000, 1'b1, 1'b0, 32'hDEAD_BEEF);
        setReq(1, 1'b1, 32'h1008, 1'b1, 1'b0, 32'h0);
        resetAndCheck("reset2");
        setReq(0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0);
        setReq(1, 1'b1, 32'h1003, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus("contend");
            checkOutput("contend_grant", 32'(obsReady), (i % 2 == 1) ? 32'h2 : 32'h1);
            if (i > 0)
                checkOutput("contend_rsp", 32'(obsRv), (i % 2 == 1) ? 32'h1 : 32'h2);
        end
        setReq(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        setReq(1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus("contend_tail");

        $display("[TB] byte path");
        setReq(0, 1'b1, 32'h1003, 1'b1, 1'b1, 32'h0000_00A5);
        applyStimulus("sb_1003");
        setReq(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        setReq(1, 1'b1, 32'h1003, 1'b0, 1'b1, 32'h0);
        applyStimulus("lbu_1003");
        checkOutput("lbu_data", rsp_rdata, 32'h0000_00A5);
        setReq(1, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0);
        applyStimulus("lw_1000_b");
        checkOutput("byte_merge", rsp_rdata, 32'hA5AD_BEEF);

        $display("[TB] errors");
        setReq(1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        setReq(0, 1'b1, 32'h0FFC, 1'b1, 1'b0, 32'hFFFF_FFFF);
        applyStimulus("sw_0ffc");
        checkOutput("err_sw_low", 32'(rsp_err), 32'h1);
        setReq(0, 1'b1, 32'h0002_0000, 1'b0, 1'b0, 32'h0);
        applyStimulus("lw_20000");
        checkOutput("err_lw_high", 32'(rsp_err), 32'h1);
        checkOutput("err_lw_high_data", rsp_rdata, 32'h0);
        setReq(0, 1'b1, 32'h1002, 1'b0, 1'b0, 32'h0);
        applyStimulus("lw_1002");
        checkOutput("err_misaligned", 32'(rsp_err), 32'h1);
        setReq(0, 1'b1, 32'h1002, 1'b0, 1'b1, 32'h0);
        applyStimulus("lbu_1002");
        checkOutput("lbu_1002_ok_valid", 32'(rsp_valid), 32'h1);
        checkOutput("lbu_1002_ok_err", 32'(rsp_err), 32'h0);

        $display("[TB] stability");
        setReq(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        setReq(1, 1'b1, 32'h1010, 1'b0, 1'b0, 32'h0);
        applyStimulus("stab_prime");
        setReq(0, 1'b1, 32'h1020, 1'b0, 1'b0, 32'h0);
        setReq(1, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus("stab");
            if (k > 0 && obsRv[1]) cnt++;
            if (obsReady[1]) setReq(1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            setReq(0, 1'b1, 32'h1000 + 32'(4 * k), 1'b0, 1'b0, 32'h0);
        end
        checkOutput("stab_rsp_count", 32'(cnt), 32'h1);

        $display("[TB] async reset mid-burst");
        setReq(0, 1'b1, 32'h1030, 1'b1, 1'b0, 32'hCAFE_0000);
        setReq(1, 1'b1, 32'h1034, 1'b1, 1'b0, 32'hCAFE_0001);
        applyStimulus("burst0");
        applyStimulus("burst1");
        setReq(0, 1'b1, 32'h1038, 1'b1, 1'b0, 32'hBAD0_BAD0);
        #2;
        resetAndCheck("midreset");
        setReq(0, 1'b1, 32'h1038, 1'b0, 1'b0, 32'h0);
        setReq(1, 1'b1, 32'h1034, 1'b0, 1'b0, 32'h0);
        applyStimulus("post_reset");
        checkOutput("post_reset_winner", 32'(obsReady), 32'h1);

        $display("[TB] random traffic");
        newReq(0);
        newReq(1);
        for (int n = 0; n < 400; n++) begin
            applyStimulus("rand");
            for (int p = 0; p < 2; p++)
                if (!req_valid[p] || (lastGrant && lastWin == p)) newReq(p);
        end
        setReq(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        setReq(1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus("drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
